pipeline_if_stage: RTL

Instruction-fetch stage directly upstream of the ID stage. Owns the fetch PC and issues one word fetch at a time to instruction memory over a req/ready + rvalid handshake. Registers the returned instruction and its PC into the IF/ID outputs, and inserts NOP bubbles when nothing is available. Supports stall from hazard logic and flush/redirect from branch/jump resolution; holds at most one outstanding request and one skid entry.

---
 rtl/pipeline_pkg.sv | 27 ++
 rtl/if_skid_buffer.sv | 27 ++
 rtl/pipeline_if_stage.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared fetch-stage types and constants: word sizes, bubble encoding, fetch FSM states.
package pipeline_pkg;

  localparam int unsigned XLEN = 64;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] DEFAULT_NOP_INST = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = '0;
  localparam logic [XLEN-1:0] PC_STEP          = 64'd4;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  // Instructions are word aligned; low two address bits are discarded on redirect.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~{{(XLEN-2){1'b0}}, 2'b11};
  endfunction

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry {instruction, pc} holding register used while ID is stalled.
module if_skid_buffer
  import pipeline_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  fetch_entry_t load_entry,
  output logic         valid,
  output fetch_entry_t entry
);

  // Clear wins over load so a flush in the same cycle always empties the entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      entry <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      entry <= load_entry;
    end
  end

endmodule

// File: rtl/pipeline_if_stage.sv
// Instruction-fetch stage: owns the fetch PC, one outstanding imem request, IF/ID output register.
module pipeline_if_stage
  import pipeline_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [ILEN-1:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_IF,
  input  logic            flush_IF,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [ILEN-1:0] instruction_ID,
  output logic [XLEN-1:0] pc_ID,
  output logic            valid_ID
);

  fetch_state_e    state;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] req_pc;
  logic            drop;

  logic            skid_load;
  logic            skid_clear;
  logic            skid_valid;
  fetch_entry_t    skid_in;
  fetch_entry_t    skid_out;

  // Gated by reset so no request escapes while the memory side is also held in reset.
  assign imem_req  = reset && (state == FETCH_REQ);
  assign imem_addr = pc_q;

  always_comb begin
    skid_in.inst = imem_rdata;
    skid_in.pc   = req_pc;
    skid_load    = !flush_IF && (state == FETCH_WAIT) && imem_rvalid && !drop && stall_IF;
    skid_clear   = flush_IF || ((state == FETCH_HOLD) && !stall_IF);
  end

  if_skid_buffer u_skid (
    .clk        (clk),
    .reset      (reset),
    .load       (skid_load),
    .clear      (skid_clear),
    .load_entry (skid_in),
    .valid      (skid_valid),
    .entry      (skid_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= FETCH_REQ;
      pc_q           <= RESET_PC;
      req_pc         <= '0;
      drop           <= 1'b0;
      instruction_ID <= NOP_INST;
      pc_ID          <= '0;
      valid_ID       <= 1'b0;
    end else if (flush_IF) begin
      pc_q           <= align_pc(redirect_pc);
      instruction_ID <= NOP_INST;
      valid_ID       <= 1'b0;
      case (state)
        FETCH_REQ: begin
          // An accepted request is already in flight; its response must be discarded.
          if (imem_ready) begin
            state <= FETCH_WAIT;
            drop  <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            state <= FETCH_REQ;
            drop  <= 1'b0;
          end else begin
            drop  <= 1'b1;
          end
        end
        FETCH_HOLD: state <= FETCH_REQ;
        default:    state <= FETCH_REQ;
      endcase
    end else begin
      // Default IF/ID update; a load below overrides it.
      if (!stall_IF) begin
        instruction_ID <= NOP_INST;
        valid_ID       <= 1'b0;
      end
      case (state)
        FETCH_REQ: begin
          if (imem_ready) begin
            req_pc <= pc_q;
            pc_q   <= pc_q + PC_STEP;
            state  <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= FETCH_REQ;
            end else if (!stall_IF) begin
              instruction_ID <= imem_rdata;
              pc_ID          <= req_pc;
              valid_ID       <= 1'b1;
              state          <= FETCH_REQ;
            end else begin
              state <= FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall_IF) begin
            instruction_ID <= skid_out.inst;
            pc_ID          <= skid_out.pc;
            valid_ID       <= skid_valid;
            state          <= FETCH_REQ;
          end
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

  // A response is only legal while a request is in flight.
  a_rvalid_only_in_wait: assert property (
    @(posedge clk) disable iff (!reset) imem_rvalid |-> (state == FETCH_WAIT)
  );

endmodule
